// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch front end. Issues sequential word-aligned fetch requests
// to instruction memory, collects the in-order responses into a small queue
// and presents the oldest instruction (with its PC) to decode. A redirect
// flushes the queue, restarts fetch at the new PC and silently drops every
// response that belongs to requests issued before the redirect.
//
// Ports
//   clk              clock, all state on rising edge
//   reset            synchronous active-high reset
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address (word aligned)
//   imem_resp_valid  response valid (one per accepted request, in order)
//   imem_resp_data   fetched instruction
//   redirect_valid   taken branch/jump: flush and refetch
//   redirect_pc      new fetch PC (low two bits ignored)
//   if_valid         head queue entry valid toward decode
//   if_ready         decode consumes the head entry
//   if_instr         head instruction (0 when empty)
//   if_pc            PC of head instruction (0 when empty)
//   if_count         queue occupancy
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
   parameter int                pc_len     = 32,
   parameter int                inst_width = 32,
   parameter int                depth      = 4,
   parameter logic [pc_len-1:0] reset_pc   = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [pc_len-1:0]        imem_req_addr,
   input  logic                     imem_resp_valid,
   input  logic [inst_width-1:0]    imem_resp_data,
   input  logic                     redirect_valid,
   input  logic [pc_len-1:0]        redirect_pc,
   output logic                     if_valid,
   input  logic                     if_ready,
   output logic [inst_width-1:0]    if_instr,
   output logic [pc_len-1:0]        if_pc,
   output logic [$clog2(depth):0]   if_count
);

   localparam int ptr_w = $clog2(depth);
   localparam int cnt_w = ptr_w + 1;
   localparam logic [cnt_w:0]    depth_v = (cnt_w + 1)'(depth);
   localparam logic [pc_len-1:0] pc_step = pc_len'(4);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state, state_nxt;
   logic [pc_len-1:0]   fetch_pc, fetch_pc_nxt;
   // PC of the next response that will be kept; responses return in request
   // order, so this is enough to tag each entry without a PC side-queue.
   logic [pc_len-1:0]   resp_pc, resp_pc_nxt;
   logic [cnt_w-1:0]    outstanding, outstanding_nxt;
   logic [cnt_w-1:0]    drop_cnt, drop_cnt_nxt;
   logic [cnt_w-1:0]    count, count_nxt;
   logic [ptr_w-1:0]    rd_ptr, rd_ptr_nxt;
   logic [ptr_w-1:0]    wr_ptr, wr_ptr_nxt;
   logic [cnt_w:0]      occ_sum;
   logic [pc_len-1:0]   redirect_base;

   logic [inst_width-1:0] q_instr [depth];
   logic [pc_len-1:0]     q_pc    [depth];

   logic req_fire;
   logic resp_ok;
   logic enq;
   logic deq;
   logic unused_redirect_low;

   assign unused_redirect_low = ^redirect_pc[1:0];
   assign redirect_base       = {redirect_pc[pc_len-1:2], 2'b00};

   // Requests in flight count against queue space so a burst of responses
   // can always be absorbed.
   assign occ_sum        = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid = (state == RUN) && (occ_sum < depth_v);
   assign imem_req_addr  = fetch_pc;

   assign req_fire = imem_req_valid & imem_req_ready;
   // A response with nothing outstanding is a protocol error and is dropped.
   assign resp_ok  = imem_resp_valid & (outstanding != '0);
   assign enq      = resp_ok & (state == RUN) & ~redirect_valid;
   assign deq      = if_valid & if_ready;

   assign if_count = count;
   assign if_valid = (count != '0);
   assign if_instr = if_valid ? q_instr[rd_ptr] : '0;
   assign if_pc    = if_valid ? q_pc[rd_ptr]    : '0;

   assign outstanding_nxt = outstanding + cnt_w'(req_fire) - cnt_w'(resp_ok);

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = req_fire ? fetch_pc + pc_step : fetch_pc;
      resp_pc_nxt  = enq ? resp_pc + pc_step : resp_pc;
      drop_cnt_nxt = drop_cnt;
      count_nxt    = count + cnt_w'(enq) - cnt_w'(deq);
      rd_ptr_nxt   = deq ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr_nxt   = enq ? wr_ptr + 1'b1 : wr_ptr;

      case (state)
         IDLE:  state_nxt = RUN;
         RUN:   state_nxt = RUN;
         DRAIN: begin
            if (resp_ok) begin
               drop_cnt_nxt = drop_cnt - 1'b1;
               if (drop_cnt == cnt_w'(1)) state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Redirect wins over everything else in the cycle. Whatever is still
      // in flight after this cycle's handshakes must be discarded later.
      if (redirect_valid) begin
         fetch_pc_nxt = redirect_base;
         resp_pc_nxt  = redirect_base;
         count_nxt    = '0;
         rd_ptr_nxt   = '0;
         wr_ptr_nxt   = '0;
         drop_cnt_nxt = outstanding_nxt;
         state_nxt    = (outstanding_nxt != '0) ? DRAIN : RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         fetch_pc    <= reset_pc;
         resp_pc     <= reset_pc;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         resp_pc     <= resp_pc_nxt;
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_cnt_nxt;
         count       <= count_nxt;
         rd_ptr      <= rd_ptr_nxt;
         wr_ptr      <= wr_ptr_nxt;
      end
   end

   // Queue storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_instr[wr_ptr] <= imem_resp_data;
         q_pc[wr_ptr]    <= resp_pc;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [2:0]  if_count;

   logic        u2_req_valid;
   logic [31:0] u2_req_addr;
   logic        u2_if_valid;
   logic [31:0] u2_unused_instr;
   logic [31:0] u2_unused_pc;
   logic [2:0]  u2_unused_count;

   int          n_chk = 0;
   int          n_bad = 0;
   int          nreq  = 0;
   logic        resp_hold;
   logic [31:0] pend[$];

   always #5 clk = ~clk;

   inst_fetch_unit #(.pc_len(32), .inst_width(32), .depth(4), .reset_pc(32'h0)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
      .if_pc(if_pc), .if_count(if_count)
   );

   inst_fetch_unit #(.pc_len(32), .inst_width(32), .depth(4), .reset_pc(32'hFFFF_FFF8)) u2 (
      .clk(clk), .reset(reset),
      .imem_req_valid(u2_req_valid), .imem_req_ready(1'b1),
      .imem_req_addr(u2_req_addr),
      .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .if_valid(u2_if_valid), .if_ready(1'b1), .if_instr(u2_unused_instr),
      .if_pc(u2_unused_pc), .if_count(u2_unused_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle, entered and left at the falling edge. Memory model:
   // accepted requests answer on the next cycle with data = ~address.
   task automatic cyc();
      if (imem_req_valid && imem_req_ready) begin
         pend.push_back(imem_req_addr);
         nreq++;
      end
      @(posedge clk);
      @(negedge clk);
      if (!resp_hold && pend.size() > 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = ~pend.pop_front();
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      pend.delete();
      nreq  = 0;
      reset = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      if_ready        = 1'b1;
      resp_hold       = 1'b0;

      // reset state
      do_reset();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_if_valid",  64'(if_valid),       64'd0);
      chk("rst_if_count",  64'(if_count),       64'd0);
      chk("rst_if_instr",  64'(if_instr),       64'd0);
      chk("rst_if_pc",     64'(if_pc),          64'd0);
      chk("rst_addr",      64'(imem_req_addr),  64'd0);

      // streaming fetch, 1-cycle memory, decode always ready
      cyc();
      chk("s_addr0",   64'(imem_req_addr), 64'h0);
      chk("s_valid0",  64'(imem_req_valid), 64'd1);
      chk("w_addr0",   64'(u2_req_addr), 64'hFFFF_FFF8);
      chk("w_valid0",  64'(u2_req_valid), 64'd1);
      cyc();
      chk("s_addr1",   64'(imem_req_addr), 64'h4);
      chk("s_ifv1",    64'(if_valid), 64'd0);
      chk("w_addr1",   64'(u2_req_addr), 64'hFFFF_FFFC);
      cyc();
      chk("s_addr2",   64'(imem_req_addr), 64'h8);
      chk("s_ifv2",    64'(if_valid), 64'd1);
      chk("s_pc2",     64'(if_pc), 64'h0);
      chk("s_ins2",    64'(if_instr), 64'hFFFF_FFFF);
      chk("w_addr2",   64'(u2_req_addr), 64'h0);
      chk("w_ifv2",    64'(u2_if_valid), 64'd0);
      cyc();
      chk("s_pc3",     64'(if_pc), 64'h4);
      chk("s_ins3",    64'(if_instr), 64'hFFFF_FFFB);
      cyc();
      chk("s_pc4",     64'(if_pc), 64'h8);
      chk("s_ins4",    64'(if_instr), 64'hFFFF_FFF7);

      // decode stalled: queue fills, requests stop at four
      do_reset();
      if_ready = 1'b0;
      repeat (10) cyc();
      chk("f_nreq",    64'(nreq), 64'd4);
      chk("f_count",   64'(if_count), 64'd4);
      chk("f_reqv",    64'(imem_req_valid), 64'd0);
      chk("f_pc",      64'(if_pc), 64'h0);
      chk("f_ins",     64'(if_instr), 64'hFFFF_FFFF);
      if_ready = 1'b1;
      cyc();
      if_ready = 1'b0;
      chk("f_count_d", 64'(if_count), 64'd3);
      chk("f_pc_d",    64'(if_pc), 64'h4);
      chk("f_reqv_d",  64'(imem_req_valid), 64'd1);
      chk("f_addr_d",  64'(imem_req_addr), 64'h10);

      // redirect with two requests outstanding
      do_reset();
      if_ready  = 1'b1;
      resp_hold = 1'b1;
      repeat (3) cyc();
      chk("r_addr_pre", 64'(imem_req_addr), 64'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      imem_req_ready = 1'b0;
      resp_hold      = 1'b0;
      cyc();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      chk("r_reqv0",  64'(imem_req_valid), 64'd0);
      chk("r_addr0",  64'(imem_req_addr), 64'h100);
      chk("r_ifv0",   64'(if_valid), 64'd0);
      cyc();
      chk("r_reqv1",  64'(imem_req_valid), 64'd0);
      chk("r_ifv1",   64'(if_valid), 64'd0);
      cyc();
      chk("r_reqv2",  64'(imem_req_valid), 64'd1);
      chk("r_addr2",  64'(imem_req_addr), 64'h100);
      chk("r_ifv2",   64'(if_valid), 64'd0);
      cyc();
      chk("r_ifv3",   64'(if_valid), 64'd0);
      cyc();
      chk("r_ifv4",   64'(if_valid), 64'd1);
      chk("r_pc4",    64'(if_pc), 64'h100);
      chk("r_ins4",   64'(if_instr), 64'hFFFF_FEFF);

      // redirect and dequeue in the same cycle, three entries queued
      do_reset();
      if_ready = 1'b0;
      repeat (5) cyc();
      chk("q_count_pre", 64'(if_count), 64'd3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      if_ready       = 1'b1;
      cyc();
      redirect_valid = 1'b0;
      chk("q_count",  64'(if_count), 64'd0);
      chk("q_ifv",    64'(if_valid), 64'd0);
      chk("q_pc",     64'(if_pc), 64'h0);
      chk("q_ins",    64'(if_instr), 64'h0);
      chk("q_reqv",   64'(imem_req_valid), 64'd1);
      chk("q_addr",   64'(imem_req_addr), 64'h200);
      cyc();
      chk("q_ifv1",   64'(if_valid), 64'd0);
      cyc();
      chk("q_ifv2",   64'(if_valid), 64'd1);
      chk("q_pc2",    64'(if_pc), 64'h200);
      chk("q_ins2",   64'(if_instr), 64'hFFFF_FDFF);

      // memory not ready: request held stable
      do_reset();
      imem_req_ready = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("h_reqv", 64'(imem_req_valid), 64'd1);
         chk("h_addr", 64'(imem_req_addr), 64'h0);
      end

      // reset in the middle of DRAIN
      imem_req_ready = 1'b1;
      resp_hold      = 1'b1;
      repeat (2) cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      imem_req_ready = 1'b0;
      cyc();
      redirect_valid = 1'b0;
      chk("d_reqv",   64'(imem_req_valid), 64'd0);
      chk("d_addr",   64'(imem_req_addr), 64'h40);
      resp_hold      = 1'b0;
      imem_req_ready = 1'b1;
      reset          = 1'b1;
      cyc();
      pend.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      reset           = 1'b0;
      chk("x_reqv",   64'(imem_req_valid), 64'd0);
      chk("x_ifv",    64'(if_valid), 64'd0);
      chk("x_count",  64'(if_count), 64'd0);
      chk("x_pc",     64'(if_pc), 64'h0);
      chk("x_ins",    64'(if_instr), 64'h0);
      chk("x_addr",   64'(imem_req_addr), 64'h0);
      cyc();
      chk("x_reqv1",  64'(imem_req_valid), 64'd1);
      chk("x_addr1",  64'(imem_req_addr), 64'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
